// File: rtl/tt_microtile_pwm_bank.sv
// Bank of CHANNELS PWM outputs driven from the 8-bit ui_in command bus.
// Duty writes land in shadow registers and are committed at each period boundary.
module tt_microtile_pwm_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out
);

    localparam logic [7:0]       PSC_LAST = 8'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = '1;

    logic [7:0]          s1_q, s1_d;
    logic [7:0]          s2_q, s2_d;
    logic                s3_q, s3_d;
    logic [7:0]          psc_q, psc_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [WIDTH-1:0]    active_q [CHANNELS];
    logic [WIDTH-1:0]    active_d [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                mark_q, mark_d;

    logic                wr;
    logic [2:0]          wr_idx;
    logic [WIDTH-1:0]    wr_duty;
    logic                tick;
    logic                boundary;

    // ui_in is asynchronous; bit 7 gets a third stage so its rising edge can be detected
    always_comb begin
        s1_d    = ui_in;
        s2_d    = s1_q;
        s3_d    = s2_q[7];
        wr      = s2_q[7] & ~s3_q;
        wr_idx  = s2_q[6:4];
        wr_duty = s2_q[WIDTH-1:0];
    end

    always_comb begin
        tick     = (psc_q == PSC_LAST);
        psc_d    = tick ? 8'd0 : psc_q + 8'd1;
        cnt_d    = tick ? cnt_q + WIDTH'(1) : cnt_q;
        boundary = tick && (cnt_q == CNT_LAST);
        mark_d   = (cnt_q == '0) && (psc_q == 8'd0);
    end

    // Out-of-range indices match no channel, so such writes fall away naturally
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            shadow_d[c] = shadow_q[c];
            active_d[c] = active_q[c];
            pwm_d[c]    = (cnt_q < active_q[c]);
            if (wr && (wr_idx == 3'(c))) begin
                shadow_d[c] = wr_duty;
            end
            if (boundary) begin
                active_d[c] = shadow_q[c];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 8'h00;
            s2_q   <= 8'h00;
            s3_q   <= 1'b0;
            psc_q  <= 8'd0;
            cnt_q  <= '0;
            pwm_q  <= '0;
            mark_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                shadow_q[c] <= '0;
                active_q[c] <= '0;
            end
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            psc_q  <= psc_d;
            cnt_q  <= cnt_d;
            pwm_q  <= pwm_d;
            mark_q <= mark_d;
            for (int c = 0; c < CHANNELS; c++) begin
                shadow_q[c] <= shadow_d[c];
                active_q[c] <= active_d[c];
            end
        end
    end

    always_comb begin
        uo_out                 = 8'h00;
        uo_out[CHANNELS-1:0]   = pwm_q;
        uo_out[7]              = mark_q;
    end

endmodule

// File: tb/tb_tt_microtile_pwm_bank.sv
// Scoreboard bench for tt_microtile_pwm_bank: default instance plus a PRESCALE=3 instance.
module tb_tt_microtile_pwm_bank;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ui_in, uo_out;
    logic [7:0] ui_in_p3, uo_out_p3;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    logic [7:0] samp [0:63];
    int   exp_duty [4];

    tt_microtile_pwm_bank #(.CHANNELS(4), .WIDTH(4), .PRESCALE(1)) u_dut (
        .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out)
    );

    tt_microtile_pwm_bank #(.CHANNELS(4), .WIDTH(4), .PRESCALE(3)) u_dut_p3 (
        .clk(clk), .rst(rst), .ui_in(ui_in_p3), .uo_out(uo_out_p3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [63:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", obs, ~obs);
            return;
        end
        e = sb_q.pop_front();
        chk(e.tag, obs, e.exp);
    endtask

    function automatic logic [7:0] get_uo(input bit p3);
        return p3 ? uo_out_p3 : uo_out;
    endfunction

    function automatic logic [63:0] duty_pat(input int d);
        logic [63:0] one;
        one = 64'd1;
        return (one << d) - 64'd1;
    endfunction

    function automatic logic [63:0] bit_pat(input int b, input int len);
        logic [63:0] p;
        logic [7:0]  s;
        p = '0;
        for (int i = 0; i < len; i++) begin
            s    = samp[i];
            p[i] = s[b];
        end
        return p;
    endfunction

    task automatic wait_mark(input bit p3, input int budget);
        logic [7:0] u;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            u = get_uo(p3);
            if (u[7]) return;
        end
        chk("mark_timeout", 64'd0, 64'd1);
    endtask

    task automatic mark_spacing(input bit p3, input int budget, output int n);
        logic [7:0] u;
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            u = get_uo(p3);
            if (u[7]) begin
                n = i;
                return;
            end
        end
    endtask

    // First sample is taken at the current negedge (normally the marker cycle)
    task automatic capture(input bit p3, input int len);
        samp[0] = get_uo(p3);
        for (int i = 1; i < len; i++) begin
            @(negedge clk);
            samp[i] = get_uo(p3);
        end
    endtask

    task automatic write_cmd(input int idx, input int duty);
        @(negedge clk);
        ui_in = {1'b1, 3'(idx), 4'(duty)};
        @(negedge clk);
        ui_in = 8'h00;
        repeat (3) @(negedge clk);
        if (idx < 4) exp_duty[idx] = duty;
    endtask

    task automatic expect_period();
        for (int c = 0; c < 4; c++) sb_push($sformatf("ch%0d_pat", c), duty_pat(exp_duty[c]));
        sb_push("mark_pat", 64'd1);
        sb_push("spare_bits", 64'd0);
    endtask

    task automatic check_period();
        logic [63:0] spare;
        wait_mark(1'b0, 40);
        capture(1'b0, 16);
        for (int c = 0; c < 4; c++) sb_pop(bit_pat(c, 16));
        sb_pop(bit_pat(7, 16));
        spare = bit_pat(4, 16) | bit_pat(5, 16) | bit_pat(6, 16);
        sb_pop(spare);
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        ui_in    = 8'h00;
        ui_in_p3 = 8'h00;
        for (int c = 0; c < 4; c++) exp_duty[c] = 0;

        // reset state
        repeat (2) @(negedge clk);
        sb_push("rst_uo", 64'h00);
        sb_pop(64'(uo_out));
        sb_push("rst_uo_p3", 64'h00);
        sb_pop(64'(uo_out_p3));
        rst = 1'b0;

        // idle: outputs low, marker every 16 cycles
        wait_mark(1'b0, 40);
        sb_push("idle_spacing", 64'd16);
        mark_spacing(1'b0, 40, n);
        sb_pop(64'(n));
        expect_period();
        check_period();

        // basic write ch0 = 5
        write_cmd(0, 5);
        expect_period();
        check_period();

        // extremes
        write_cmd(1, 8);
        write_cmd(2, 0);
        write_cmd(3, 15);
        expect_period();
        check_period();

        // glitch-free update of ch1 mid-period
        sb_push("glitch_cur", duty_pat(8));
        sb_push("glitch_next", duty_pat(3) << 16);
        sb_push("glitch_mark", 64'h0001_0001);
        wait_mark(1'b0, 40);
        samp[0] = uo_out;
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            samp[i] = uo_out;
            if (i == 4) ui_in = 8'h93;
            if (i == 5) ui_in = 8'h00;
        end
        exp_duty[1] = 3;
        sb_pop(bit_pat(1, 32) & 64'h0000_FFFF);
        sb_pop(bit_pat(1, 32) & 64'hFFFF_0000);
        sb_pop(bit_pat(7, 32));

        // dropped write to index 5
        write_cmd(5, 9);
        expect_period();
        check_period();

        // held strobe with changing duty: only the first value counts
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ui_in = {1'b1, 3'd1, 4'(10 + i)};
        end
        @(negedge clk);
        ui_in = 8'h00;
        repeat (3) @(negedge clk);
        exp_duty[1] = 10;
        expect_period();
        check_period();

        // retrigger after a single low cycle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ui_in = 8'h9C;
        end
        @(negedge clk);
        ui_in = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ui_in = 8'h96;
        end
        @(negedge clk);
        ui_in = 8'h00;
        repeat (3) @(negedge clk);
        exp_duty[1] = 6;
        expect_period();
        check_period();

        // asynchronous reset mid-run
        wait_mark(1'b0, 40);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        sb_push("rst_async", 64'h00);
        sb_pop(64'(uo_out));
        sb_push("rst_async_p3", 64'h00);
        sb_pop(64'(uo_out_p3));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) exp_duty[c] = 0;
        wait_mark(1'b0, 40);
        sb_push("post_rst_spacing", 64'd16);
        mark_spacing(1'b0, 40, n);
        sb_pop(64'(n));
        expect_period();
        check_period();
        expect_period();
        check_period();

        // PRESCALE=3 instance: ch0 duty 2
        @(negedge clk);
        ui_in_p3 = 8'h82;
        @(negedge clk);
        ui_in_p3 = 8'h00;
        repeat (3) @(negedge clk);
        wait_mark(1'b1, 120);
        sb_push("p3_spacing", 64'd48);
        mark_spacing(1'b1, 120, n);
        sb_pop(64'(n));
        sb_push("p3_ch0_high", 64'd6);
        sb_push("p3_ch0_pat", 64'h3F);
        sb_push("p3_mark_count", 64'd1);
        capture(1'b1, 48);
        sb_pop(64'($countones(bit_pat(0, 48))));
        sb_pop(bit_pat(0, 48));
        sb_pop(64'($countones(bit_pat(7, 48))));

        if (sb_q.size() != 0) chk("sb_leftover", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tt_microtile_pwm_bank.md
Name: tt_microtile_pwm_bank

Overview:
- Parametrised, clocked successor to the combinational microtile wrapper. It keeps the same 8-bit ui_in / uo_out pin contract.
- Provides CHANNELS independent PWM outputs.
- Duty values are written through a strobed command on ui_in. Each value is staged in a shadow register and becomes active only at a period boundary, so outputs never glitch mid-period.
- Instantiated directly by the microtile top and by its testbench.

Parameters:
- CHANNELS, 4, number of PWM channels, legal 1..7 (uo_out[7] is reserved for the period marker).
- WIDTH, 4, PWM counter / duty width in bits, legal 1..4 (duty field is ui_in[WIDTH-1:0]).
- PRESCALE, 1, clk cycles per PWM counter step, legal 1..255.

Ports:
- clk  input  1  system clock, all state rising-edge.
- rst  input  1  asynchronous, active-high reset.
- ui_in  input  8  command bus: [7] write strobe, [6:4] channel index, [3:0] duty (upper bits above WIDTH ignored); asynchronous to clk.
- uo_out  output  8  [CHANNELS-1:0] PWM outputs, [7] period-start pulse, remaining bits 0.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. Asserting rst immediately clears all synchroniser flops, prescaler, period counter, shadow and active duty registers, and uo_out to 8'h00. This holds mid-operation too; there is no partial-write recovery.
- Input sync: ui_in passes through a 2-flop synchroniser (s1, s2), plus a third flop s3 on bit 7 only.
- Write detect: wr = s2[7] & ~s3[7], i.e. rising edge of the strobe only. A held strobe causes exactly one write; a new write requires strobe low for at least 1 synchronised cycle.
- Write action: on a clk edge with wr=1, shadow[s2[6:4]] <= s2[WIDTH-1:0].
  - Index >= CHANNELS: write silently dropped, no state change.
  - Latency: strobe first sampled at edge E0 -> shadow updated at E2.
- Prescaler: counts 0..PRESCALE-1. tick=1 on the cycle the count equals PRESCALE-1, then the count wraps to 0. PRESCALE=1 gives tick=1 every cycle.
- Period counter cnt (WIDTH bits):
  - Increments on tick.
  - Wraps from 2^WIDTH-1 to 0, so a period is 2^WIDTH ticks.
- Boundary load: on the edge where tick=1 and cnt=2^WIDTH-1, every active[c] <= shadow[c]. This includes a shadow value written on that same edge's prior cycle. A write and the boundary on the same edge: the shadow takes the new value, and active takes the pre-write shadow value.
- Outputs (registered):
  - uo_out[c] <= (cnt < active[c]) for c < CHANNELS. Output lags cnt by 1 cycle.
  - Duty 0: constantly low. Duty 2^WIDTH-1: high for 2^WIDTH-1 of 2^WIDTH ticks; 100% is not available.
  - uo_out[7] <= (cnt==0 && prescaler==0): 1-cycle pulse at each period start.
  - Bits CHANNELS..6 are tied 0.
- No combinational path from ui_in to uo_out.

Test Plan (CHANNELS=4, WIDTH=4, PRESCALE=1 unless stated):
- Reset/idle: assert rst mid-run with duties loaded -> uo_out=8'h00 immediately. After release, uo_out[3:0]=0 and uo_out[7] pulses every 16 cycles.
- Basic write: ui_in=8'h85 then 8'h05 -> shadow[0]=5 at E2. From the next period, uo_out[0] is high 5 of every 16 cycles and aligned to the uo_out[7] pulse.
- Glitch-free update: ch1 at duty 8. Write duty 3 at cnt=4 -> current period still gives 8 high cycles on uo_out[1]; the following period gives 3.
- Extremes and drop: duty 0 on ch2 -> constant 0. Duty 15 on ch3 -> 15/16 high. Write to index 5 (ui_in=8'hD9) -> no output change on any channel.
- Held strobe / retrigger: hold ui_in[7]=1 for 10 cycles while changing ui_in[3:0] -> only the value present at the synchronised edge is written. Drop the strobe for 1 cycle, then raise it again -> a second write occurs.
- Prescaler: PRESCALE=3 -> period 48 cycles, and uo_out[7] pulse spacing is 48. Duty 2 gives 6 high cycles per period.
